// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg
//   Shared widths, reset/enable encodings, default sizing and FSM state type
//   for the register-file write-back arbiter and its pending-result buffer.
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;

  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
  typedef logic [REG_BUS-1:0]      reg_word_t;

  localparam logic      RST_ENABLE   = 1'b0;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam reg_word_t ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  localparam int WB_BUF_DEPTH    = 2;
  localparam int WB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STALL
  } arb_state_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if
//   Bundles the pipeline write-back, long-latency result, register-file write
//   and decode hazard signals. slave = arbiter side, master = surroundings.
interface reg_wb_arbiter_if;
  import reg_wb_arbiter_pkg::*;

  logic      wb_we;
  reg_addr_t wb_waddr;
  reg_word_t wb_wdata;
  logic      lu_valid;
  reg_addr_t lu_waddr;
  reg_word_t lu_wdata;
  logic      lu_ready;
  logic      rf_we;
  reg_addr_t rf_waddr;
  reg_word_t rf_wdata;
  reg_addr_t rd1_addr;
  reg_addr_t rd2_addr;
  logic      rd1_pending;
  logic      rd2_pending;
  logic      stall_req;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rd1_addr, rd2_addr,
    output rd1_pending, rd2_pending,
    output stall_req
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rd1_addr, rd2_addr,
    input  rd1_pending, rd2_pending,
    input  stall_req
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_pend_fifo.sv
// wb_pend_fifo
//   Ordered (oldest at index 0) buffer of pending long-latency writes.
//   Supports push, pop of the head, squash of every entry matching an
//   address, and reports per-entry address matches for two query ports.
//   Entries are re-packed every edge so the valid ones are always contiguous
//   from index 0; full/head therefore come straight from fixed slots.
// Ports: cpu_clk_75M/cpu_rst_n clock and sync active-low reset; push/pop/
//   squash controls; q1/q2 query addresses -> match vectors; head entry,
//   full flag and next-cycle non-empty indication.
module wb_pend_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_BUF_DEPTH
) (
  input  logic             cpu_clk_75M,
  input  logic             cpu_rst_n,
  input  logic             push,
  input  reg_addr_t        push_addr,
  input  reg_word_t        push_data,
  input  logic             pop,
  input  logic             squash,
  input  reg_addr_t        squash_addr,
  input  reg_addr_t        q1_addr,
  input  reg_addr_t        q2_addr,
  output logic [DEPTH-1:0] q1_match,
  output logic [DEPTH-1:0] q2_match,
  output logic             head_valid,
  output reg_addr_t        head_addr,
  output reg_word_t        head_data,
  output logic             full,
  output logic             nonempty_next
);

  logic [DEPTH-1:0] ent_valid;
  reg_addr_t        ent_addr [DEPTH];
  reg_word_t        ent_data [DEPTH];

  logic [DEPTH-1:0] keep;
  logic [DEPTH-1:0] nxt_valid;
  reg_addr_t        nxt_addr [DEPTH];
  reg_word_t        nxt_data [DEPTH];
  int               rank [DEPTH];
  int               n_keep;

  // Survivors move to slot "rank" (number of survivors older than them);
  // an accepted push lands right behind the last survivor.
  always_comb begin
    n_keep = 0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = 1'b0;
      rank[i] = 0;
      nxt_valid[i] = 1'b0;
      nxt_addr[i]  = NOP_REG_ADDR;
      nxt_data[i]  = ZERO_WORD;
    end
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = ent_valid[i] && !(pop && (i == 0)) &&
                !(squash && (ent_addr[i] == squash_addr));
      rank[i] = n_keep;
      if (keep[i]) n_keep = n_keep + 1;
    end
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (rank[i] == j)) begin
          nxt_valid[j] = 1'b1;
          nxt_addr[j]  = ent_addr[i];
          nxt_data[j]  = ent_data[i];
        end
      end
      if (push && (n_keep == j)) begin
        nxt_valid[j] = 1'b1;
        nxt_addr[j]  = push_addr;
        nxt_data[j]  = push_data;
      end
    end
    nonempty_next = (n_keep != 0) || push;
  end

  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= NOP_REG_ADDR;
        ent_data[i] <= ZERO_WORD;
      end
    end else begin
      ent_valid <= nxt_valid;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= nxt_addr[i];
        ent_data[i] <= nxt_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q1_match[i] = ent_valid[i] && (ent_addr[i] == q1_addr);
      q2_match[i] = ent_valid[i] && (ent_addr[i] == q2_addr);
    end
  end

  assign head_valid = ent_valid[0];
  assign head_addr  = ent_addr[0];
  assign head_data  = ent_data[0];
  assign full       = ent_valid[DEPTH-1];

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Shares the register-file write port between the in-order write-back path
//   (absolute priority, never stalled) and buffered long-latency results,
//   flags decode read hazards on pending writes, and requests a pipeline
//   bubble when a buffered result has waited too long.
// Ports: cpu_clk_75M clock, cpu_rst_n sync active-low reset,
//   bus (slave modport) carrying wb_*, lu_*, rf_*, rd*_addr/pending, stall_req.
//
// state    | meaning
// ST_IDLE  | buffer empty
// ST_WAIT  | buffer holds results, head waiting for a free write slot
// ST_STALL | head starved, stall_req high until it drains
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_BUF_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input logic              cpu_clk_75M,
  input logic              cpu_rst_n,
  reg_wb_arbiter_if.slave  bus
);

  localparam int              CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STARVE_LIMIT);

  logic             run;
  logic             full;
  logic             head_valid;
  reg_addr_t        head_addr;
  reg_word_t        head_data;
  logic             nonempty_next;
  logic [DEPTH-1:0] q1_match;
  logic [DEPTH-1:0] q2_match;
  logic             push;
  logic             pop;
  logic             squash;
  logic             waiting;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign run = (cpu_rst_n != RST_ENABLE);

  // A same-cycle pipeline write to the same register is younger, so the
  // incoming long-latency value is dropped rather than buffered.
  assign push   = bus.lu_valid && !full && (bus.lu_waddr != NOP_REG_ADDR) &&
                  !(bus.wb_we && (bus.wb_waddr == bus.lu_waddr));
  assign squash = bus.wb_we && (bus.wb_waddr != NOP_REG_ADDR);
  assign pop    = !bus.wb_we && head_valid;

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .cpu_clk_75M   (cpu_clk_75M),
    .cpu_rst_n     (cpu_rst_n),
    .push          (push),
    .push_addr     (bus.lu_waddr),
    .push_data     (bus.lu_wdata),
    .pop           (pop),
    .squash        (squash),
    .squash_addr   (bus.wb_waddr),
    .q1_addr       (bus.rd1_addr),
    .q2_addr       (bus.rd2_addr),
    .q1_match      (q1_match),
    .q2_match      (q2_match),
    .head_valid    (head_valid),
    .head_addr     (head_addr),
    .head_data     (head_data),
    .full          (full),
    .nonempty_next (nonempty_next)
  );

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = NOP_REG_ADDR;
    bus.rf_wdata = ZERO_WORD;
    if (run) begin
      if (bus.wb_we) begin
        bus.rf_we    = WRITE_ENABLE;
        bus.rf_waddr = bus.wb_waddr;
        bus.rf_wdata = bus.wb_wdata;
      end else if (head_valid) begin
        bus.rf_we    = WRITE_ENABLE;
        bus.rf_waddr = head_addr;
        bus.rf_wdata = head_data;
      end
    end
  end

  assign bus.lu_ready    = run && !full;
  assign bus.rd1_pending = run && (bus.rd1_addr != NOP_REG_ADDR) &&
                           ((|q1_match) || (bus.lu_valid && (bus.lu_waddr == bus.rd1_addr)));
  assign bus.rd2_pending = run && (bus.rd2_addr != NOP_REG_ADDR) &&
                           ((|q2_match) || (bus.lu_valid && (bus.lu_waddr == bus.rd2_addr)));
  assign bus.stall_req   = (state_q == ST_STALL);

  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    waiting    = head_valid && !pop;
    wait_cnt_d = '0;
    state_d    = nonempty_next ? ST_WAIT : ST_IDLE;
    if (waiting) begin
      // Saturate: only reachable if the pipeline ignores stall_req.
      wait_cnt_d = (wait_cnt_q == CNT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE:  ;
      ST_WAIT:  if (waiting && (wait_cnt_q == STALL_AT)) state_d = ST_STALL;
      ST_STALL: if (waiting) state_d = ST_STALL;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule
